// File: rtl/seg_scan_display.sv
// Time-multiplexed 4-digit hex seven-segment driver with frame-aligned capture
// and optional leading-zero blanking; AN/BCD are active-low registered pins.
module seg_scan_display #(
  parameter int SCAN_DIV = 100000,
  parameter bit LZB      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        display,
  input  logic [15:0] result,
  input  logic [3:0]  dp,
  output logic [3:0]  AN,
  output logic [7:0]  BCD
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] r_div_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [3:0]    r_shadow_dp;
  logic [3:0]    r_an;
  logic [7:0]    r_bcd;

  logic          w_tick;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg;
  logic          w_blank;
  logic          w_dp_on;
  logic          w_lit;
  logic [3:0]    w_an_next;
  logic [7:0]    w_bcd_next;

  assign w_tick = (r_div_cnt == CW'(SCAN_DIV - 1));

  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    w_nibble = r_shadow[4*r_idx +: 4];
    w_seg    = 7'h7F;
    case (w_nibble)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase

    // A digit is a leading zero when it and every more-significant nibble are zero.
    w_blank = 1'b0;
    unique case (r_idx)
      2'd0: w_blank = 1'b0;
      2'd1: w_blank = (r_shadow[15:4]  == 12'h000);
      2'd2: w_blank = (r_shadow[15:8]  == 8'h00);
      2'd3: w_blank = (r_shadow[15:12] == 4'h0);
    endcase
    w_blank = w_blank && LZB;

    w_dp_on    = r_shadow_dp[r_idx];
    // A blank slot with no dp keeps its anode off entirely to avoid ghosting.
    w_lit      = display && (!w_blank || w_dp_on);
    w_an_next  = w_lit ? ~(4'b0001 << r_idx) : 4'b1111;
    w_bcd_next = w_lit ? {~w_dp_on, (w_blank ? 7'h7F : w_seg)} : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_idx       <= 2'd0;
      r_shadow    <= 16'h0000;
      r_shadow_dp <= 4'h0;
      r_an        <= 4'b1111;
      r_bcd       <= 8'hFF;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_div_cnt <= w_tick ? '0 : r_div_cnt + CW'(1);
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_shadow    <= result;
          r_shadow_dp <= dp;
        end
      end
      r_an  <= w_an_next;
      r_bcd <= w_bcd_next;
    end
  end

  assign AN  = r_an;
  assign BCD = r_bcd;

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Time-multiplexed 4-digit seven-segment driver on the board-output side of the pipeline top.
- Consumes the 16-bit result word and the display enable produced by the pipeline, and drives the anode-select and segment pins.
- Shows the word as four hex digits, digit 0 = bits [3:0], rightmost.
- Captures the input word only at frame boundaries, so a changing result never shows a torn mix of old and new digits.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays lit (≥2); 100 MHz gives 1 ms per digit and a 250 Hz frame.
- LZB, 1: 1 = blank leading zero digits; 0 = always show all four digits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- display  input  1  enable; 0 = all digits dark, scanning continues.
- result  input  16  value to show, four hex nibbles.
- dp  input  4  decimal point per digit, active-high, bit i = digit i.
- AN  output  4  anode select, active-low, one-hot-low when lit.
- BCD  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (reset=1 at a clock edge): div_cnt=0, idx=0, shadow=16'h0000, shadow_dp=4'h0, AN=4'b1111, BCD=8'hFF. Reset mid-frame aborts the frame, with no partial-state carry-over.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (div_cnt==SCAN_DIV-1).
  - On tick, idx advances 0→1→2→3→0 (2-bit wrap).
- Frame capture: on tick with idx==3, i.e. idx wrapping to 0, shadow<=result and shadow_dp<=dp at that same edge. result/dp changes at any other time have no effect until the next wrap.
- Output register: AN/BCD are registered and computed each cycle from the current idx, shadow, shadow_dp and display. There is one cycle of latency from an idx or shadow change to the pins.
- Anode: AN = ~(4'b0001<<idx) when the digit is lit, else 4'b1111.
- Hex decode of nibble shadow[4*idx+:4], giving segments [6:0]:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - BCD[7] = ~shadow_dp[idx].
- Leading-zero blanking (LZB=1):
  - digit k (k=3,2,1) is blank if nibbles k..3 of shadow are all zero.
  - digit 0 is never blanked.
  - A blank digit still shows its dp: AN active, BCD[6:0]=7'h7F, BCD[7]=~dp bit.
  - A blank digit with dp=0 drives AN=4'b1111 for that slot, so no ghosting.
- display=0: AN=4'b1111, BCD=8'hFF from the next edge. Divider, idx and frame capture keep running.
- display 0→1: the lit digit appears on the next edge at the current idx, with no frame realignment.
- Simultaneous reset and tick: reset wins.
- Duty: each digit is lit for exactly SCAN_DIV cycles per 4*SCAN_DIV-cycle frame, offset by the one-cycle output latency.

Test Plan:
- Reset/first frame: SCAN_DIV=4, LZB=0, display=1, result=16'h1234, release reset at cycle 0 → cycles 1-4 show AN=1110, BCD=C0 (shadow still 0). result is captured at cycle 16. In the next frame, AN=1110/BCD=99, then 1101/B0, then 1011/A4, then 0111/F9, each 4 cycles.
- Tear-free capture: change result from 16'hABCD to 16'h0F0F mid-frame (idx=1) → the remaining digits of that frame still show D,C,B,A patterns (A1, C6, 83, 88). The new value appears only after wrap: 8E, C0, 8E, C0.
- Leading-zero blanking: LZB=1, result=16'h0050, dp=0 → digit 0=C0, digit 1=92, digits 2,3 with AN=1111. With result=16'h0000, only digit 0 is lit (C0). With dp=4'b1000 and result=0, digit 3 gives AN=0111, BCD=7F.
- Disable: display=0 for 10 cycles mid-frame → AN=1111, BCD=FF one cycle after the drop. idx keeps advancing. On re-enable, output resumes at the correct current digit.
- Reset mid-operation: assert reset at idx=2, div_cnt=1 → next edge AN=1111, BCD=FF, idx=0, shadow=0. Scan restarts from digit 0 with a full SCAN_DIV dwell.
- Hex coverage: result=16'h89EF then 16'h0123…, sweeping all 16 nibble values with LZB=0 → each segment code matches the decode table, and dp bits clear only BCD[7].
